// File: rtl/vexbus_arbiter.sv
// vexbus_arbiter: arbitrates the VexRiscv instruction/data buses and the debug memory
// port onto one synchronous-read bus. Define VEXBUS_RR_EN for alternating I/D priority.
module vexbus_arbiter #(
   parameter bit ERR_ON_UNMAPPED = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic        icmd_valid,
   output logic        icmd_ready,
   input  logic [31:0] icmd_adr,
   output logic        irsp_valid,
   output logic        irsp_error,
   output logic [31:0] irsp_inst,
   input  logic        dcmd_valid,
   output logic        dcmd_ready,
   input  logic        dcmd_wr,
   input  logic [3:0]  dcmd_mask,
   input  logic [31:0] dcmd_adr,
   input  logic [31:0] dcmd_data,
   output logic        drsp_valid,
   output logic        drsp_error,
   output logic [31:0] drsp_data,
   input  logic        dbg_mem_op,
   input  logic        dbg_rw,
   input  logic [31:0] dbg_adr,
   input  logic [31:0] dbg_do,
   output logic [31:0] dbg_di,
   output logic        dbg_mem_rdy,
   output logic        mem_op,
   output logic [31:0] mem_adr,
   output logic [3:0]  mem_wren,
   output logic [31:0] mem_di,
   input  logic [31:0] mem_do,
   input  logic        mem_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_DWAIT} state_t;
   typedef enum logic [1:0] {SRC_I, SRC_D, SRC_DBG} src_t;

   // Handshake: icmd/dcmd transfer on a rising edge where valid & ready; ready is high
   // only in IDLE for the arbitration winner and depends only on state and the requests.
   // Debug is a level request held until the one-cycle dbg_mem_rdy completion pulse.
   state_t      state;
   state_t      state_nxt;
   src_t        src_q;
   logic [31:0] adr_q;
   logic [31:0] data_q;
   logic [3:0]  mask_q;
   logic        wr_q;
   logic        err_q;
   logic        rsp_err;

   logic        i_req;
   logic        d_req;
   logic        d_win;
   logic        i_win;
   logic        grant;

   assign i_req = icmd_valid & cpu_en;
   assign d_req = dcmd_valid & cpu_en;

`ifdef VEXBUS_RR_EN
   // fetch_first flips after every CPU grant so a pending loser wins next time.
   logic fetch_first;
   assign d_win = ~dbg_mem_op & d_req & ~(i_req & fetch_first);
   assign i_win = ~dbg_mem_op & i_req & ~(d_req & ~fetch_first);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_first <= 1'b0;
      end else if (state == S_IDLE && !dbg_mem_op) begin
         if (d_win)      fetch_first <= 1'b1;
         else if (i_win) fetch_first <= 1'b0;
      end
   end
`else
   assign d_win = ~dbg_mem_op & d_req;
   assign i_win = ~dbg_mem_op & i_req & ~d_req;
`endif

   assign grant   = dbg_mem_op | d_win | i_win;
   assign rsp_err = err_q & ERR_ON_UNMAPPED;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (grant) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   state_nxt = (src_q == SRC_DBG) ? S_DWAIT : S_IDLE;
         S_DWAIT:  if (!dbg_mem_op) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Request capture at acceptance; the bus error is sampled while the address is driven.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q  <= SRC_I;
         adr_q  <= '0;
         data_q <= '0;
         mask_q <= '0;
         wr_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (state == S_IDLE) begin
            if (dbg_mem_op) begin
               src_q  <= SRC_DBG;
               adr_q  <= dbg_adr;
               data_q <= dbg_do;
               mask_q <= 4'b1111;
               wr_q   <= ~dbg_rw;
            end else if (d_win) begin
               src_q  <= SRC_D;
               adr_q  <= dcmd_adr;
               data_q <= dcmd_data;
               mask_q <= dcmd_mask;
               wr_q   <= dcmd_wr;
            end else if (i_win) begin
               src_q  <= SRC_I;
               adr_q  <= icmd_adr;
               data_q <= '0;
               mask_q <= '0;
               wr_q   <= 1'b0;
            end
         end
         if (state == S_ACCESS) err_q <= mem_err;
      end
   end

   // Output logic: everything idles at 0 so responses can be OR-combined upstream.
   always_comb begin
      icmd_ready  = 1'b0;
      dcmd_ready  = 1'b0;
      mem_op      = 1'b0;
      mem_adr     = '0;
      mem_wren    = '0;
      mem_di      = '0;
      irsp_valid  = 1'b0;
      irsp_error  = 1'b0;
      irsp_inst   = '0;
      drsp_valid  = 1'b0;
      drsp_error  = 1'b0;
      drsp_data   = '0;
      dbg_di      = '0;
      dbg_mem_rdy = 1'b0;
      case (state)
         S_IDLE: begin
            icmd_ready = i_win;
            dcmd_ready = d_win;
         end
         S_ACCESS: begin
            mem_op   = 1'b1;
            mem_adr  = adr_q;
            mem_di   = data_q;
            mem_wren = (wr_q && !mem_err) ? mask_q : 4'b0000;
         end
         S_RESP: begin
            case (src_q)
               SRC_I: begin
                  irsp_valid = 1'b1;
                  irsp_inst  = mem_do;
                  irsp_error = rsp_err;
               end
               SRC_D: begin
                  if (!wr_q) begin
                     drsp_valid = 1'b1;
                     drsp_data  = mem_do;
                     drsp_error = rsp_err;
                  end
               end
               SRC_DBG: begin
                  dbg_mem_rdy = 1'b1;
                  if (!wr_q) dbg_di = mem_do;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vexbus_arbiter.sv
// Directed bench for vexbus_arbiter with a small synchronous-read memory model;
// a second instance with ERR_ON_UNMAPPED=0 shadows the first for the error-flag check.
module tb_vexbus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, cpu_en;
   logic        icmd_valid, dcmd_valid, dcmd_wr, dbg_mem_op, dbg_rw;
   logic [31:0] icmd_adr, dcmd_adr, dcmd_data, dbg_adr, dbg_do;
   logic [3:0]  dcmd_mask;
   logic        icmd_ready, irsp_valid, irsp_error, dcmd_ready, drsp_valid, drsp_error;
   logic        dbg_mem_rdy, mem_op, mem_err;
   logic [31:0] irsp_inst, drsp_data, dbg_di, mem_adr, mem_di, mem_do;
   logic [3:0]  mem_wren;
   logic        b_icmd_ready, b_irsp_valid, b_irsp_error, b_dcmd_ready, b_drsp_valid;
   logic        b_drsp_error, b_dbg_mem_rdy, b_mem_op;
   logic [31:0] b_irsp_inst, b_drsp_data, b_dbg_di, b_mem_adr, b_mem_di;
   logic [3:0]  b_mem_wren;

   int n_vec = 0;
   int n_bad = 0;

   vexbus_arbiter #(.ERR_ON_UNMAPPED(1'b1)) dut (
      .clk(clk), .reset(reset), .cpu_en(cpu_en),
      .icmd_valid(icmd_valid), .icmd_ready(icmd_ready), .icmd_adr(icmd_adr),
      .irsp_valid(irsp_valid), .irsp_error(irsp_error), .irsp_inst(irsp_inst),
      .dcmd_valid(dcmd_valid), .dcmd_ready(dcmd_ready), .dcmd_wr(dcmd_wr),
      .dcmd_mask(dcmd_mask), .dcmd_adr(dcmd_adr), .dcmd_data(dcmd_data),
      .drsp_valid(drsp_valid), .drsp_error(drsp_error), .drsp_data(drsp_data),
      .dbg_mem_op(dbg_mem_op), .dbg_rw(dbg_rw), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
      .dbg_di(dbg_di), .dbg_mem_rdy(dbg_mem_rdy),
      .mem_op(mem_op), .mem_adr(mem_adr), .mem_wren(mem_wren), .mem_di(mem_di),
      .mem_do(mem_do), .mem_err(mem_err)
   );

   vexbus_arbiter #(.ERR_ON_UNMAPPED(1'b0)) dut_noerr (
      .clk(clk), .reset(reset), .cpu_en(cpu_en),
      .icmd_valid(icmd_valid), .icmd_ready(b_icmd_ready), .icmd_adr(icmd_adr),
      .irsp_valid(b_irsp_valid), .irsp_error(b_irsp_error), .irsp_inst(b_irsp_inst),
      .dcmd_valid(dcmd_valid), .dcmd_ready(b_dcmd_ready), .dcmd_wr(dcmd_wr),
      .dcmd_mask(dcmd_mask), .dcmd_adr(dcmd_adr), .dcmd_data(dcmd_data),
      .drsp_valid(b_drsp_valid), .drsp_error(b_drsp_error), .drsp_data(b_drsp_data),
      .dbg_mem_op(dbg_mem_op), .dbg_rw(dbg_rw), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
      .dbg_di(b_dbg_di), .dbg_mem_rdy(b_dbg_mem_rdy),
      .mem_op(b_mem_op), .mem_adr(b_mem_adr), .mem_wren(b_mem_wren), .mem_di(b_mem_di),
      .mem_do(mem_do), .mem_err(mem_err)
   );

   // Memory model: 0x00000-0x2FFFF mapped, 0x30000 and above unmapped.
   logic [31:0] wmem [16];
   logic [15:0] wvalid;

   function automatic logic [3:0] widx(input logic [31:0] a);
      return {a[17:16], a[3:2]};
   endfunction

   function automatic logic [31:0] init_word(input logic [3:0] i);
      case (i)
         4'd0:    return 32'h0000_0013;
         4'd1:    return 32'h0000_0093;
         4'd4:    return 32'h1111_2222;
         4'd8:    return 32'hCAFE_F00D;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return wvalid[widx(a)] ? wmem[widx(a)] : init_word(widx(a));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   assign mem_err = (mem_adr >= 32'h0003_0000);

   always @(posedge clk) begin
      if (reset) begin
         mem_do <= '0;
         wvalid <= '0;
      end else if (mem_op) begin
         mem_do <= mem_err ? 32'h0 : rd_word(mem_adr);
         if (!mem_err && (mem_wren != 4'b0000)) begin
            wmem[widx(mem_adr)]   <= merge(rd_word(mem_adr), mem_di, mem_wren);
            wvalid[widx(mem_adr)] <= 1'b1;
         end
      end
   end

   // Pulse counters, cleared by reset.
   int n_memop, n_irsp, n_drsp, n_dbgrdy;
   always @(negedge clk) begin
      if (reset) begin
         n_memop <= 0; n_irsp <= 0; n_drsp <= 0; n_dbgrdy <= 0;
      end else begin
         n_memop  <= n_memop  + (mem_op      ? 1 : 0);
         n_irsp   <= n_irsp   + (irsp_valid  ? 1 : 0);
         n_drsp   <= n_drsp   + (drsp_valid  ? 1 : 0);
         n_dbgrdy <= n_dbgrdy + (dbg_mem_rdy ? 1 : 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_fetch(input logic [31:0] adr, input logic [31:0] exp_inst);
      @(negedge clk);
      icmd_valid = 1'b1; icmd_adr = adr;
      #1 check("f_ready", 32'(icmd_ready), 32'd1);
      @(negedge clk);
      icmd_valid = 1'b0;
      check("f_mem_op", 32'(mem_op), 32'd1);
      check("f_mem_adr", mem_adr, adr);
      check("f_mem_wren", 32'(mem_wren), 32'd0);
      @(negedge clk);
      check("f_rsp_valid", 32'(irsp_valid), 32'd1);
      check("f_rsp_inst", irsp_inst, exp_inst);
      check("f_rsp_error", 32'(irsp_error), 32'd0);
   endtask

   task automatic do_data(input logic wr, input logic [3:0] mask, input logic [31:0] adr,
                          input logic [31:0] data, input logic [3:0] exp_wren,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic exp_err_b);
      @(negedge clk);
      dcmd_valid = 1'b1; dcmd_wr = wr; dcmd_mask = mask; dcmd_adr = adr; dcmd_data = data;
      #1 check("d_ready", 32'(dcmd_ready), 32'd1);
      @(negedge clk);
      dcmd_valid = 1'b0;
      check("d_mem_op", 32'(mem_op), 32'd1);
      check("d_mem_adr", mem_adr, adr);
      check("d_mem_wren", 32'(mem_wren), 32'(exp_wren));
      if (wr) check("d_mem_di", mem_di, data);
      @(negedge clk);
      check("d_rsp_valid", 32'(drsp_valid), wr ? 32'd0 : 32'd1);
      check("d_rsp_data", drsp_data, wr ? 32'd0 : exp_rdata);
      check("d_rsp_error", 32'(drsp_error), wr ? 32'd0 : 32'(exp_err));
      check("d_rsp_error_noerr", 32'(b_drsp_error), wr ? 32'd0 : 32'(exp_err_b));
   endtask

   logic [1:0] got_q[$];
   logic [1:0] exp_q[$];
   int base_memop, base_rdy, base_drsp;
   logic d_acc, i_acc;

   initial begin
      reset = 1'b1; cpu_en = 1'b1;
      icmd_valid = 1'b0; icmd_adr = '0;
      dcmd_valid = 1'b0; dcmd_wr = 1'b0; dcmd_mask = '0; dcmd_adr = '0; dcmd_data = '0;
      dbg_mem_op = 1'b0; dbg_rw = 1'b1; dbg_adr = '0; dbg_do = '0;
      repeat (2) @(negedge clk);
      check("rst_mem_op", 32'(mem_op), 32'd0);
      check("rst_mem_bus", mem_adr | mem_di | 32'(mem_wren), 32'd0);
      check("rst_strobes", 32'({irsp_valid, drsp_valid, dbg_mem_rdy, irsp_error, drsp_error}), 32'd0);
      check("rst_data", irsp_inst | drsp_data | dbg_di, 32'd0);
      check("rst_noerr_outs", 32'(|{b_icmd_ready, b_irsp_valid, b_irsp_error, b_dcmd_ready,
            b_drsp_valid, b_dbg_mem_rdy, b_mem_op, b_irsp_inst, b_drsp_data, b_dbg_di,
            b_mem_adr, b_mem_di, b_mem_wren}), 32'd0);
      reset = 1'b0;

      do_fetch(32'h0, 32'h0000_0013);

      #1 base_drsp = n_drsp;
      do_data(1'b1, 4'b0001, 32'h1_0004, 32'h0000_005A, 4'b0001, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      #1 check("wr_no_drsp", 32'(n_drsp - base_drsp), 32'd0);
      do_data(1'b0, 4'b1111, 32'h1_0004, 32'h0, 4'b0000, 32'h0000_005A, 1'b0, 1'b0);

      do_data(1'b1, 4'b1111, 32'h3_0000, 32'hDEAD_BEEF, 4'b0000, 32'h0, 1'b0, 1'b0);
      do_data(1'b0, 4'b1111, 32'h3_0000, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0);

      // Debug read held 3 cycles past completion, with the CPU disabled and a fetch pending.
      @(negedge clk);
      #1 base_memop = n_memop; base_rdy = n_dbgrdy;
      cpu_en = 1'b0; icmd_valid = 1'b1; icmd_adr = 32'h4;
      dbg_mem_op = 1'b1; dbg_rw = 1'b1; dbg_adr = 32'h2_0000;
      @(negedge clk);
      check("dbg_mem_op", 32'(mem_op), 32'd1);
      check("dbg_mem_wren", 32'(mem_wren), 32'd0);
      @(negedge clk);
      check("dbg_rdy", 32'(dbg_mem_rdy), 32'd1);
      check("dbg_di", dbg_di, 32'hCAFE_F00D);
      repeat (3) @(negedge clk);
      dbg_mem_op = 1'b0;
      repeat (2) @(negedge clk);
      #1 check("dbg_cpu_off_ready", 32'(icmd_ready), 32'd0);
      check("dbg_one_mem_op", 32'(n_memop - base_memop), 32'd1);
      check("dbg_one_rdy", 32'(n_dbgrdy - base_rdy), 32'd1);
      icmd_valid = 1'b0; cpu_en = 1'b1;

      do_fetch(32'h4, 32'h0000_0093);

      // Debug, data and fetch all requesting together.
      exp_q = '{2'd0, 2'd1, 2'd2};
      got_q.delete();
      d_acc = 1'b0; i_acc = 1'b0;
      @(negedge clk);
      dbg_mem_op = 1'b1; dbg_rw = 1'b1; dbg_adr = 32'h2_0000;
      dcmd_valid = 1'b1; dcmd_wr = 1'b0; dcmd_adr = 32'h1_0000;
      icmd_valid = 1'b1; icmd_adr = 32'h4;
      #1 check("sim_d_ready_blocked", 32'(dcmd_ready), 32'd0);
      check("sim_i_ready_blocked", 32'(icmd_ready), 32'd0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dbg_mem_rdy) begin
            got_q.push_back(2'd0);
            check("sim_dbg_di", dbg_di, 32'hCAFE_F00D);
            dbg_mem_op = 1'b0;
         end
         if (drsp_valid) begin
            got_q.push_back(2'd1);
            check("sim_drsp_data", drsp_data, 32'h1111_2222);
         end
         if (irsp_valid) begin
            got_q.push_back(2'd2);
            check("sim_irsp_inst", irsp_inst, 32'h0000_0093);
         end
         if (d_acc) begin dcmd_valid = 1'b0; d_acc = 1'b0; end
         if (i_acc) begin icmd_valid = 1'b0; i_acc = 1'b0; end
         #1;
         if (dcmd_ready) d_acc = 1'b1;
         if (icmd_ready) i_acc = 1'b1;
      end
      check("sim_count", 32'(got_q.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         check($sformatf("sim_order%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(exp_q[i]));

      // Data and fetch continuously pending: grant order.
`ifdef VEXBUS_RR_EN
      exp_q = '{2'd1, 2'd2, 2'd1, 2'd2};
`else
      exp_q = '{2'd1, 2'd1, 2'd1, 2'd1};
`endif
      got_q.delete();
      @(negedge clk);
      dcmd_valid = 1'b1; dcmd_wr = 1'b0; dcmd_adr = 32'h1_0000;
      icmd_valid = 1'b1; icmd_adr = 32'h0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (dcmd_ready) got_q.push_back(2'd1);
         if (icmd_ready) got_q.push_back(2'd2);
         @(negedge clk);
         if (got_q.size() >= 4) break;
      end
      dcmd_valid = 1'b0; icmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("grant_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("grant%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(exp_q[i]));

      // Reset while the bus is being driven.
      @(negedge clk);
      icmd_valid = 1'b1; icmd_adr = 32'h0;
      #1 check("rstmid_ready", 32'(icmd_ready), 32'd1);
      @(negedge clk);
      icmd_valid = 1'b0;
      check("rstmid_pre_mem_op", 32'(mem_op), 32'd1);
      #1 reset = 1'b1;
      #1 check("rstmid_mem_op", 32'(mem_op), 32'd0);
      check("rstmid_mem_bus", mem_adr | mem_di | 32'(mem_wren), 32'd0);
      check("rstmid_strobes", 32'({irsp_valid, drsp_valid, dbg_mem_rdy}), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      do_fetch(32'h0, 32'h0000_0013);
      repeat (2) @(negedge clk);
      #1 check("rstmid_one_irsp", 32'(n_irsp), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
